s_pea_out_stream: RTL and testbench

S_PEA_OUT_STREAM -- requirements
Module: s_pea_out_stream

---
 rtl/s_pea_out_stream.sv | 175 +++++++++++++++++
 tb/tb_s_pea_out_stream.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_pea_out_stream.sv
// Collects a configured number of PE results into a first-word-fall-through buffer and streams them downstream.
// Optional feature: define MAGE_OUT_STREAM_LAST_EN to add m_last_o, a per-entry end-of-run flag.
module s_pea_out_stream #(
   parameter int N_BITS     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk_cg,
   input  logic                            rst_n_i,
   input  logic                            start_i,
   input  logic [15:0]                     cfg_len_i,
   input  logic [N_BITS-1:0]               pe_res_i,
   input  logic                            pe_valid_i,
   output logic                            pea_ready_o,
   output logic [N_BITS-1:0]               m_data_o,
   output logic                            m_valid_o,
   input  logic                            m_ready_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic [$clog2(FIFO_DEPTH):0]     occupancy_o
`ifdef MAGE_OUT_STREAM_LAST_EN
   ,
   output logic                            m_last_o
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]    occ_q, occ_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [N_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic [N_BITS-1:0]   mem_d [FIFO_DEPTH];
`ifdef MAGE_OUT_STREAM_LAST_EN
   logic [FIFO_DEPTH-1:0] last_q, last_d;
`endif

   logic                push_s;
   logic                pop_s;
   logic                final_s;
   logic [15:0]         cnt_inc_s;

   // Handshake decode: accept from the PEA only while running with room, pop on downstream handshake.
   always_comb begin
      pea_ready_o = (state_q == ST_RUN) && (occ_q < OCC_W'(FIFO_DEPTH));
      m_valid_o   = (occ_q != {OCC_W{1'b0}});
      m_data_o    = mem_q[rd_ptr_q];
      push_s      = pe_valid_i && pea_ready_o;
      pop_s       = m_valid_o && m_ready_i;
      cnt_inc_s   = cnt_q + 16'd1;
      final_s     = (cnt_inc_s == len_q);
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign occupancy_o = occ_q;
`ifdef MAGE_OUT_STREAM_LAST_EN
   assign m_last_o    = last_q[rd_ptr_q];
`endif

   // Run-control next state: length latch, accepted count and phase sequencing.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               len_d   = cfg_len_i;
               cnt_d   = 16'd0;
               state_d = (cfg_len_i != 16'd0) ? ST_RUN : ST_DONE;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (push_s) begin
               cnt_d   = cnt_inc_s;
               state_d = final_s ? ST_DRAIN : ST_RUN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // A pop of the last remaining entry counts as empty this cycle.
            if ((occ_q == {OCC_W{1'b0}}) || ((occ_q == OCC_W'(1)) && pop_s)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   // Buffer next state: pointers, fill level and entry storage.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
`ifdef MAGE_OUT_STREAM_LAST_EN
      last_d   = last_q;
`endif
      if (push_s) begin
         mem_d[wr_ptr_q] = pe_res_i;
`ifdef MAGE_OUT_STREAM_LAST_EN
         last_d[wr_ptr_q] = final_s;
`endif
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // State registers; reset discards buffer contents and returns to idle.
   always_ff @(posedge clk_cg or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         len_q    <= 16'd0;
         cnt_q    <= 16'd0;
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         occ_q    <= {OCC_W{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= {N_BITS{1'b0}};
         end
`ifdef MAGE_OUT_STREAM_LAST_EN
         last_q   <= {FIFO_DEPTH{1'b0}};
`endif
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         mem_q    <= mem_d;
`ifdef MAGE_OUT_STREAM_LAST_EN
         last_q   <= last_d;
`endif
      end
   end

endmodule

// File: tb/tb_s_pea_out_stream.sv
// Randomized directed bench for s_pea_out_stream against a queue-based reference model.
module tb_s_pea_out_stream;

   localparam int NB = 32;
   localparam int D  = 4;
   localparam int OW = 3;

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic          clk_cg = 1'b0;
   logic          rst_n_i;
   logic          start_i;
   logic [15:0]   cfg_len_i;
   logic [NB-1:0] pe_res_i;
   logic          pe_valid_i;
   logic          pea_ready_o;
   logic [NB-1:0] m_data_o;
   logic          m_valid_o;
   logic          m_ready_i;
   logic          busy_o;
   logic          done_o;
   logic [OW-1:0] occupancy_o;
`ifdef MAGE_OUT_STREAM_LAST_EN
   logic          m_last_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: queue of buffered results, run phase, length and accepted count
   logic [NB-1:0] mq[$];
   bit            lq[$];
   int            ph;
   int            m_len;
   int            m_acc;

   always #5 clk_cg = ~clk_cg;

   s_pea_out_stream #(.N_BITS(NB), .FIFO_DEPTH(D)) dut (
      .clk_cg      (clk_cg),
      .rst_n_i     (rst_n_i),
      .start_i     (start_i),
      .cfg_len_i   (cfg_len_i),
      .pe_res_i    (pe_res_i),
      .pe_valid_i  (pe_valid_i),
      .pea_ready_o (pea_ready_o),
      .m_data_o    (m_data_o),
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .occupancy_o (occupancy_o)
`ifdef MAGE_OUT_STREAM_LAST_EN
      ,
      .m_last_o    (m_last_o)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      lq.delete();
      ph    = P_IDLE;
      m_len = 0;
      m_acc = 0;
   endtask

   task automatic check_outputs();
      chk("pea_ready", {63'd0, pea_ready_o}, {63'd0, (ph == P_RUN) && (mq.size() < D)});
      chk("m_valid", {63'd0, m_valid_o}, {63'd0, mq.size() != 0});
      if (mq.size() != 0) begin
         chk("m_data", {32'd0, m_data_o}, {32'd0, mq[0]});
`ifdef MAGE_OUT_STREAM_LAST_EN
         chk("m_last", {63'd0, m_last_o}, {63'd0, lq[0]});
`endif
      end
      chk("occupancy", {61'd0, occupancy_o}, 64'(mq.size()));
      chk("busy", {63'd0, busy_o}, {63'd0, (ph == P_RUN) || (ph == P_DRAIN)});
      chk("done", {63'd0, done_o}, {63'd0, ph == P_DONE});
   endtask

   // one clock: check outputs, then advance the model across the rising edge
   task automatic cycle();
      bit acc;
      bit pop;
      check_outputs();
      acc = pe_valid_i && (ph == P_RUN) && (mq.size() < D);
      pop = (mq.size() != 0) && m_ready_i;
      @(posedge clk_cg);
      case (ph)
         P_IDLE, P_DONE: begin
            if (start_i) begin
               m_len = int'(cfg_len_i);
               m_acc = 0;
               ph    = (cfg_len_i != 16'd0) ? P_RUN : P_DONE;
            end
         end
         P_RUN: begin
            if (acc) begin
               m_acc++;
               if (m_acc == m_len) ph = P_DRAIN;
            end
         end
         default: begin
            if ((mq.size() == 0) || ((mq.size() == 1) && pop)) ph = P_DONE;
         end
      endcase
      if (pop) begin
         void'(mq.pop_front());
         void'(lq.pop_front());
      end
      if (acc) begin
         mq.push_back(pe_res_i);
         lq.push_back(m_acc == m_len);
      end
      @(negedge clk_cg);
   endtask

   task automatic drive(input int n, input int vp, input int rp, input int sp);
      for (int i = 0; i < n; i++) begin
         pe_valid_i = ($urandom_range(0, 99) < vp);
         m_ready_i  = ($urandom_range(0, 99) < rp);
         pe_res_i   = $urandom;
         start_i    = ((ph == P_RUN) || (ph == P_DRAIN)) && ($urandom_range(0, 99) < sp);
         cfg_len_i  = 16'($urandom);
         cycle();
      end
      start_i = 1'b0;
   endtask

   task automatic start_run(input int len);
      start_i    = 1'b1;
      cfg_len_i  = 16'(len);
      pe_valid_i = 1'($urandom);
      pe_res_i   = $urandom;
      cycle();
      start_i    = 1'b0;
   endtask

   task automatic finish_run(input int vp, input int rp, input int budget);
      int k = 0;
      while ((ph != P_DONE) && (k < budget)) begin
         drive(1, vp, rp, 15);
         k++;
      end
      chk("run_done", {63'd0, done_o}, 64'd1);
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk_cg);
      check_outputs();
      rst_n_i = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      int k;
      rst_n_i    = 1'b0;
      start_i    = 1'b0;
      cfg_len_i  = 16'd0;
      pe_res_i   = '0;
      pe_valid_i = 1'b0;
      m_ready_i  = 1'b0;
      model_reset();

      // reset state
      @(negedge clk_cg);
      do_reset();
      drive(2, 100, 100, 0);

      // basic run: 0xA, 0xB, 0xC streamed with downstream always ready
      start_run(3);
      i = 0;
      k = 0;
      while ((i < 3) && (k < 20)) begin
         bit rdy;
         rdy        = (ph == P_RUN) && (mq.size() < D);
         pe_res_i   = 32'hA + 32'(i);
         pe_valid_i = 1'b1;
         m_ready_i  = 1'b1;
         cycle();
         if (rdy) i++;
         k++;
      end
      chk("basic_accepts", 64'(i), 64'd3);
      pe_valid_i = 1'b0;
      finish_run(0, 100, 20);

      // backpressure until full, then release
      start_run(6);
      drive(8, 100, 0, 0);
      chk("bp_occ_full", {61'd0, occupancy_o}, 64'd4);
      chk("bp_ready_low", {63'd0, pea_ready_o}, 64'd0);
      drive(1, 100, 100, 0);
      chk("full_pop_ready", {63'd0, pea_ready_o}, 64'd1);
      finish_run(100, 100, 50);

      // zero length goes straight to done
      pe_valid_i = 1'b1;
      start_run(0);
      chk("zero_done", {63'd0, done_o}, 64'd1);
      drive(3, 100, 100, 0);

      // mid-run reset after two accepts
      start_run(5);
      k = 0;
      while ((m_acc < 2) && (k < 20)) begin
         drive(1, 100, 0, 0);
         k++;
      end
      do_reset();
      chk("reset_occ", {61'd0, occupancy_o}, 64'd0);
      drive(2, 100, 100, 0);
      start_run(4);
      finish_run(70, 70, 200);

      // randomized runs with spurious start pulses
      for (int r = 0; r < 12; r++) begin
         start_run($urandom_range(1, 12));
         finish_run($urandom_range(30, 100), $urandom_range(30, 100), 400);
         drive($urandom_range(0, 3), 50, 50, 0);
      end

`ifdef MAGE_OUT_STREAM_LAST_EN
      // last flag on the second beat, start ignored while draining
      start_run(2);
      k = 0;
      while ((ph != P_DRAIN) && (k < 20)) begin
         drive(1, 100, 0, 0);
         k++;
      end
      start_i    = 1'b1;
      cfg_len_i  = 16'd7;
      pe_valid_i = 1'b1;
      m_ready_i  = 1'b0;
      cycle();
      start_i    = 1'b0;
      chk("drain_start_ignored", {63'd0, busy_o}, 64'd1);
      finish_run(100, 100, 20);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
